ahb_ddr3_memtest_master: RTL and testbench
==========================================

# ahb_ddr3_memtest_master

AHB-Lite initiator that self-tests the DDR3 memory behind the DDR3 AHB responder. It has two passes. The write pass fills a region with an address-derived pattern using INCR4 bursts. The read pass reads the region back and compares every beat. The block connects to the 64-bit DDR AHB port in place of the AE350 core, for board bring-up and production test, and reports pass/fail with error statistics.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of first beat; 32-byte aligned
- WORDS, 1024, number of 64-bit beats tested; multiple of 4, ≥4
- SEED, 32'hA5A5_5A5A, pattern seed

Ports:
- HCLK  in  1  sole clock, shared with the DDR AHB responder
- HRST  in  1  synchronous, active-high reset
- START  in  1  one-cycle start pulse
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  level; held until next accepted START or reset
- PASS  out  1  valid while DONE is high; 1 = ERR_COUNT==0 and BUS_ERR==0
- BUS_ERR  out  1  an HRESP ERROR was received
- ERR_COUNT  out  16  mismatching read beats; saturates at 16'hFFFF
- FIRST_ERR_ADDR  out  32  HADDR of the first mismatching beat
- HADDR  out  32
- HTRANS  out  2
- HWRITE  out  1
- HSIZE  out  3  constant 3'b011
- HBURST  out  3  constant 3'b011 (INCR4)
- HPROT  out  4  constant 4'b0011
- HWDATA  out  64
- HREADY  in  1  responder HREADY_O
- HRESP  in  1  0 = OKAY, 1 = ERROR
- HRDATA  in  64

## Operation
- Pattern for the beat at byte address A: {A ^ SEED, A}.
- States: IDLE → WRITE → RD → FIN. Any state → ABORT on ERROR. ABORT → FIN.
- IDLE:
  - HTRANS = IDLE.
  - START accepted only here; START in any other state is ignored.
  - On START, clear ERR_COUNT, FIRST_ERR_ADDR, BUS_ERR, DONE and PASS, then go to WRITE.
- WRITE:
  - Issues WORDS/4 INCR4 bursts. Beat k uses HADDR = BASE_ADDR + 8k.
  - HTRANS is NONSEQ on beats with k%4==0 and SEQ otherwise.
  - Bursts are back-to-back; no BUSY transfers are ever issued.
  - HWRITE = 1. HWDATA for beat k is driven in its data phase (cycle after its address phase is accepted).
  - After the last address phase is accepted, HTRANS = IDLE until the last data phase completes.
  - Then go to RD.
- RD:
  - Same address sequence with HWRITE = 0.
  - HRDATA is sampled on each data-phase cycle with HREADY = 1 and compared to the pattern of that beat's address.
  - On mismatch: ERR_COUNT increments (saturating). FIRST_ERR_ADDR is loaded only when ERR_COUNT was 0.
  - After the last data phase completes, go to FIN.
- FIN: DONE = 1, BUSY = 0, PASS computed, HTRANS = IDLE. Go to IDLE in the same cycle.
- ABORT:
  - Entered in the first ERROR cycle (HRESP = 1, HREADY = 0).
  - HTRANS = IDLE is driven from the next cycle; BUS_ERR = 1; remaining beats are skipped.
  - Go to FIN.
- Address/control change only when HREADY = 1 (AHB pipeline hold rule). HWDATA is held stable through wait states.

## Timing
- Reset values (cycle after HRST is sampled high):
  - HTRANS 2'b00, HADDR BASE_ADDR, HWRITE 0, HWDATA 0.
  - HSIZE / HBURST / HPROT at their constants.
  - BUSY, DONE, PASS, BUS_ERR 0; ERR_COUNT 0; FIRST_ERR_ADDR 0.
- HRST mid-operation: outputs return to reset values at the next edge; the test is discarded. The responder shares this reset domain.
- Zero-wait-state schedule, with START high at edge 0:
  - First NONSEQ at cycle 1.
  - Write address phases: cycles 1..WORDS. Last write data phase: WORDS+1.
  - Read address phases: WORDS+2..2·WORDS+1. Last read data phase: 2·WORDS+2.
  - DONE rises at cycle 2·WORDS+3.
- Each wait state (HREADY = 0) extends the schedule by exactly one cycle.
- The HRDATA comparison is registered; ERR_COUNT reflects a beat one cycle after its data phase completes, and before DONE rises.
- START and last-beat completion in the same cycle: START is ignored.

## Test plan
- WORDS=8, zero-wait responder model, BASE_ADDR=0:
  - HTRANS sequence is NONSEQ,SEQ,SEQ,SEQ ×2 for the write pass, then the same for the read pass.
  - DONE at cycle 19, PASS = 1, ERR_COUNT = 0.
  - Write to 0x18 carries data {0x18^SEED, 0x18}.
- Same as above with random HREADY stalls (about 30%):
  - HADDR and HWDATA are stable during every stall.
  - DONE cycle = 19 + number of stall cycles; PASS = 1.
- Responder corrupts read beats at 0x20 and 0x38:
  - ERR_COUNT = 2, FIRST_ERR_ADDR = 0x20, PASS = 0.
- Responder returns ERROR on the write to 0x10:
  - HTRANS = IDLE from the cycle after the first ERROR cycle.
  - BUS_ERR = 1, DONE = 1, PASS = 0; no read transfers are issued.
- START pulsed while BUSY: no restart and the schedule is unchanged. A START after DONE clears the statistics and reruns the test.
- HRST asserted mid read pass: next cycle HTRANS = IDLE, BUSY = 0, DONE = 0, ERR_COUNT = 0.

Source files
------------

// File: rtl/ahb_ddr3_memtest_master.sv
// ahb_ddr3_memtest_master
//   AHB-Lite initiator that self-tests the DDR3 memory behind the DDR AHB
//   responder. The write pass fills WORDS 64-bit beats starting at BASE_ADDR
//   with the pattern {A ^ SEED, A} using back-to-back INCR4 bursts. The read
//   pass reads the same region back and compares every beat, then reports
//   PASS/DONE together with the error statistics.
//
//   Ports
//     HCLK, HRST        clock, synchronous active-high reset
//     START             one-cycle start pulse (accepted only when idle)
//     BUSY, DONE, PASS  test status (DONE is a level held until next START)
//     BUS_ERR           an HRESP ERROR terminated the test
//     ERR_COUNT         mismatching read beats (saturating)
//     FIRST_ERR_ADDR    address of the first mismatching beat
//     HADDR..HWDATA     AHB-Lite master address/control/write-data outputs
//     HREADY, HRESP,
//     HRDATA            AHB-Lite responder inputs
module ahb_ddr3_memtest_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        BUS_ERR,
  output logic [15:0] ERR_COUNT,
  output logic [31:0] FIRST_ERR_ADDR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  localparam int unsigned CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  // FIN is not a resting state: the finishing action (DONE/PASS update and
  // return to IDLE) happens on the edge that completes the last data phase.
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_RD, ST_ABORT} state_t;
  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  state_t        state;
  logic [CW-1:0] addr_idx;   // beat index of the current address phase
  logic          dp_valid;   // a transfer is in its data phase
  logic          dp_last;    // that transfer is the last beat of the pass
  logic [31:0]   dp_addr;    // address of the transfer in its data phase

  logic          rd_mismatch;
  logic [15:0]   err_next;

  assign HSIZE  = 3'b011;
  assign HBURST = 3'b011;
  assign HPROT  = 4'b0011;

  function automatic logic [63:0] pattern(input logic [31:0] a);
    return {a ^ SEED, a};
  endfunction

  assign rd_mismatch = (state == ST_RD) && dp_valid && HREADY &&
                       (HRDATA != pattern(dp_addr));

  always_comb begin
    err_next = ERR_COUNT;
    if (rd_mismatch && (ERR_COUNT != '1))
      err_next = ERR_COUNT + 16'd1;
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state          <= ST_IDLE;
      HTRANS         <= HT_IDLE;
      HADDR          <= BASE_ADDR;
      HWRITE         <= 1'b0;
      HWDATA         <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      BUS_ERR        <= 1'b0;
      ERR_COUNT      <= '0;
      FIRST_ERR_ADDR <= '0;
      addr_idx       <= '0;
      dp_valid       <= 1'b0;
      dp_last        <= 1'b0;
      dp_addr        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state          <= ST_WRITE;
            BUSY           <= 1'b1;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            BUS_ERR        <= 1'b0;
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
            HTRANS         <= HT_NONSEQ;
            HADDR          <= BASE_ADDR;
            HWRITE         <= 1'b1;
            addr_idx       <= '0;
            dp_valid       <= 1'b0;
          end
        end

        ST_WRITE, ST_RD: begin
          if (dp_valid && HRESP && !HREADY) begin
            // First ERROR cycle: cancel the pending address phase.
            state   <= ST_ABORT;
            HTRANS  <= HT_IDLE;
            BUS_ERR <= 1'b1;
          end else if (HREADY) begin
            if (state == ST_RD) begin
              ERR_COUNT <= err_next;
              if (rd_mismatch && (ERR_COUNT == '0))
                FIRST_ERR_ADDR <= dp_addr;
            end

            // NONSEQ and SEQ both have bit 1 set.
            if (HTRANS[1]) begin
              dp_valid <= 1'b1;
              dp_addr  <= HADDR;
              dp_last  <= (addr_idx == LAST_IDX);
              if (state == ST_WRITE)
                HWDATA <= pattern(HADDR);
              if (addr_idx == LAST_IDX) begin
                HTRANS <= HT_IDLE;
              end else begin
                addr_idx <= addr_idx + CW'(1);
                HADDR    <= HADDR + 32'd8;
                HTRANS   <= (addr_idx[1:0] == 2'b11) ? HT_NONSEQ : HT_SEQ;
              end
            end else begin
              dp_valid <= 1'b0;
            end

            if (dp_valid && dp_last) begin
              if (state == ST_WRITE) begin
                state    <= ST_RD;
                HTRANS   <= HT_NONSEQ;
                HADDR    <= BASE_ADDR;
                HWRITE   <= 1'b0;
                addr_idx <= '0;
                dp_valid <= 1'b0;
              end else begin
                state    <= ST_IDLE;
                HTRANS   <= HT_IDLE;
                dp_valid <= 1'b0;
                BUSY     <= 1'b0;
                DONE     <= 1'b1;
                PASS     <= (err_next == '0) && !BUS_ERR;
              end
            end
          end
        end

        ST_ABORT: begin
          // Wait out the second ERROR cycle, then finish with PASS low.
          if (HREADY) begin
            state    <= ST_IDLE;
            HTRANS   <= HT_IDLE;
            dp_valid <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            PASS     <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ddr3_memtest_master.sv
// tb_ahb_ddr3_memtest_master
//   Drives ahb_ddr3_memtest_master (WORDS=8, BASE_ADDR=0) against a
//   behavioural AHB responder with memory, optional random wait states,
//   read-data corruption and a one-shot ERROR response. Results are checked
//   against expectations computed from the address/pattern rules.
module tb_ahb_ddr3_memtest_master;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WORDS = 8;
  localparam logic [31:0] SEED  = 32'hA5A5_5A5A;
  localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

  logic        HCLK, HRST, START;
  logic        BUSY, DONE, PASS, BUS_ERR;
  logic [15:0] ERR_COUNT;
  logic [31:0] FIRST_ERR_ADDR, HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [63:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  ahb_ddr3_memtest_master #(
    .BASE_ADDR(BASE),
    .WORDS(WORDS),
    .SEED(SEED)
  ) dut (
    .HCLK(HCLK), .HRST(HRST), .START(START),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .BUS_ERR(BUS_ERR),
    .ERR_COUNT(ERR_COUNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ SEED, a};
  endfunction

  // ---------------- responder model ----------------
  logic [63:0] mem [0:63];
  bit          stall_en = 0;
  logic [31:0] err_addr = NONE;
  logic [31:0] bad_a0 = NONE, bad_a1 = NONE;
  bit          pend_v = 0, pend_w = 0;
  logic [31:0] pend_a = '0;
  int          err_ph = 0;
  logic        s_ready, s_resp, s_rst, s_write;
  logic [1:0]  s_trans;
  logic [31:0] s_addr;
  logic [63:0] s_wdata;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
  end

  // Snapshot the bus mid-cycle; these are the values the next edge samples.
  always @(negedge HCLK) begin
    #1;
    s_ready = HREADY; s_resp = HRESP; s_rst = HRST; s_trans = HTRANS;
    s_addr = HADDR; s_write = HWRITE; s_wdata = HWDATA;
  end

  always @(posedge HCLK) begin
    #1;
    if (s_rst) begin
      pend_v = 0; err_ph = 0;
    end else if (s_ready) begin
      if (pend_v && pend_w && !s_resp) mem[pend_a[8:3]] = s_wdata;
      if (pend_v) err_ph = 0;
      pend_v = s_trans[1]; pend_a = s_addr; pend_w = s_write;
    end
    HRESP = 1'b0; HREADY = 1'b1; HRDATA = '0;
    if (pend_v) begin
      if (err_ph == 1) begin
        HRESP = 1'b1; err_ph = 2;
      end else if (pend_w && pend_a == err_addr && err_ph == 0) begin
        HRESP = 1'b1; HREADY = 1'b0; err_ph = 1;
      end else if (stall_en && $urandom_range(99) < 30) begin
        HREADY = 1'b0;
      end
      if (!pend_w) begin
        HRDATA = mem[pend_a[8:3]];
        if (pend_a == bad_a0 || pend_a == bad_a1) HRDATA = HRDATA ^ 64'h0000_0100_0000_0001;
      end
    end
  end

  // ---------------- run monitor ----------------
  logic [34:0] acc_q[$];   // accepted transfers {HTRANS, HWRITE, HADDR}
  logic [34:0] exp_q[$];
  int          hold_bad;

  task automatic run_test(input bit stall, input int start_again, input int rst_at,
                          output int done_cyc, output int stalls);
    bit          wr_dp, prev_stall, prev_errf;
    logic [31:0] wr_dp_a, p_addr;
    logic [1:0]  p_trans;
    logic [63:0] p_wdata;
    stall_en = stall; acc_q.delete(); hold_bad = 0;
    done_cyc = -1; stalls = 0; wr_dp = 0; wr_dp_a = '0;
    prev_stall = 0; prev_errf = 0; p_addr = '0; p_trans = '0; p_wdata = '0;
    @(negedge HCLK); START = 1'b1;
    @(negedge HCLK);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      START = (cyc == start_again);
      if (cyc == 1) begin
        chk("busy_c1", BUSY, 1); chk("done_c1", DONE, 0);
        chk("errcnt_clr", ERR_COUNT, 0); chk("buserr_clr", BUS_ERR, 0);
        chk("first_clr", FIRST_ERR_ADDR, 0);
      end
      if (cyc == rst_at) begin
        chk("errcnt_pre_rst", ERR_COUNT, 1);
        HRST = 1'b1;
        @(negedge HCLK);
        HRST = 1'b0;
        chk("rst_htrans", HTRANS, 0); chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0); chk("rst_errcnt", ERR_COUNT, 0);
        START = 1'b0;
        return;
      end
      if (prev_errf) chk("abort_idle", HTRANS, 0);
      if (prev_stall && !prev_errf &&
          (HADDR !== p_addr || HTRANS !== p_trans || HWDATA !== p_wdata))
        hold_bad++;
      if (DONE) begin done_cyc = cyc; break; end
      if (!HREADY) stalls++;
      if (wr_dp && HREADY) chk("wdata", HWDATA, pat(wr_dp_a));
      if (HREADY) begin
        wr_dp = HTRANS[1] && HWRITE; wr_dp_a = HADDR;
        if (HTRANS[1]) acc_q.push_back({HTRANS, HWRITE, HADDR});
      end
      prev_stall = !HREADY; prev_errf = HRESP && !HREADY;
      p_addr = HADDR; p_trans = HTRANS; p_wdata = HWDATA;
      @(negedge HCLK);
    end
    START = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  // Expected results computed from the address/pattern rules.
  task automatic final_checks(input bit err_run, input int done_cyc, input int stalls);
    int          cnt, n_wr;
    logic [31:0] first, a;
    cnt = 0; first = '0;
    exp_q.delete();
    n_wr = err_run ? int'((err_addr - BASE) / 8) + 1 : WORDS;
    for (int k = 0; k < n_wr; k++) begin
      a = BASE + 32'(8 * k);
      exp_q.push_back({(k % 4 == 0) ? 2'b10 : 2'b11, 1'b1, a});
    end
    if (!err_run) begin
      for (int k = 0; k < WORDS; k++) begin
        a = BASE + 32'(8 * k);
        exp_q.push_back({(k % 4 == 0) ? 2'b10 : 2'b11, 1'b0, a});
        if (a == bad_a0 || a == bad_a1) begin
          if (cnt == 0) first = a;
          cnt++;
        end
      end
      chk("done_cycle", done_cyc, 2 * WORDS + 3 + stalls);
    end
    chk("seq_len", acc_q.size(), exp_q.size());
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      chk("seq_beat", acc_q[i], exp_q[i]);
    chk("done", DONE, 1);
    chk("busy_at_done", BUSY, 0);
    chk("pass", PASS, (cnt == 0) && !err_run);
    chk("bus_err", BUS_ERR, err_run);
    chk("err_count", ERR_COUNT, cnt);
    chk("first_err", FIRST_ERR_ADDR, first);
    chk("hold_stable", hold_bad, 0);
  endtask

  int dc, st;

  initial begin
    HRST = 1'b1; START = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rv_htrans", HTRANS, 0);   chk("rv_haddr", HADDR, BASE);
    chk("rv_hwrite", HWRITE, 0);   chk("rv_hwdata", HWDATA, 0);
    chk("rv_hsize", HSIZE, 3'b011); chk("rv_hburst", HBURST, 3'b011);
    chk("rv_hprot", HPROT, 4'b0011);
    chk("rv_status", {BUSY, DONE, PASS, BUS_ERR}, 0);
    chk("rv_errcnt", ERR_COUNT, 0); chk("rv_first", FIRST_ERR_ADDR, 0);
    HRST = 1'b0;
    repeat (2) @(negedge HCLK);

    // zero-wait clean pass
    run_test(0, 0, 0, dc, st);
    chk("done_cycle_19", dc, 19);
    final_checks(0, dc, st);

    // random stalls
    for (int r = 0; r < 3; r++) begin
      run_test(1, 0, 0, dc, st);
      final_checks(0, dc, st);
    end

    // corrupted read beats, with stalls
    bad_a0 = 32'h20; bad_a1 = 32'h38;
    run_test(1, 0, 0, dc, st);
    final_checks(0, dc, st);
    chk("corrupt_first", FIRST_ERR_ADDR, 32'h20);

    // rerun after DONE clears statistics
    bad_a0 = NONE; bad_a1 = NONE;
    run_test(0, 0, 0, dc, st);
    final_checks(0, dc, st);

    // ERROR on write to 0x10
    err_addr = 32'h10;
    run_test(0, 0, 0, dc, st);
    final_checks(1, dc, st);
    err_addr = NONE;

    // START while busy, mid-run and coinciding with last-beat completion
    run_test(0, 7, 0, dc, st);
    final_checks(0, dc, st);
    run_test(0, 18, 0, dc, st);
    final_checks(0, dc, st);
    @(negedge HCLK);
    chk("no_restart", BUSY, 0);

    // reset mid read pass
    bad_a0 = 32'h0;
    run_test(0, 0, 13, dc, st);
    bad_a0 = NONE;
    repeat (3) @(negedge HCLK);
    run_test(1, 0, 0, dc, st);
    final_checks(0, dc, st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
